// File: rtl/conv_stream_engine.sv
// Streaming convolution window engine: multiplies each incoming pixel row by the
// matching stored weight row, accumulates a full window, then presents one
// scaled, optionally rectified and saturated result behind a valid/ready handshake.
module conv_stream_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS    = 1,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(KERNEL_SIZE*KERNEL_SIZE*CHANNELS)
) (
  input  logic                                  Clk,
  input  logic                                  Rst_n,
  input  logic                                  clear,
  input  logic                                  w_we,
  input  logic [$clog2(KERNEL_SIZE*CHANNELS)-1:0] w_row,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]     w_data,
  output logic                                  w_err,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0]     in_data,
  input  logic [$clog2(ACC_WIDTH)-1:0]          shift,
  input  logic                                  relu_en,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_sat,
  output logic                                  busy
);

  localparam int ROWS = KERNEL_SIZE*CHANNELS;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(ROWS+1);
  localparam int SW   = $clog2(ACC_WIDTH);
  localparam int PW   = 2*DATA_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                        state, state_next;
  logic signed [DATA_WIDTH-1:0]  weights [ROWS][KERNEL_SIZE];
  logic signed [ACC_WIDTH-1:0]   acc, acc_next, row_sum;
  logic        [CW-1:0]          count;
  logic        [RW-1:0]          row_idx;
  logic        [SW-1:0]          shift_q, shift_eff;
  logic                          relu_q, relu_eff;
  logic                          beat, last_beat, wr_ok, out_take;
  logic signed [PW-1:0]          prod;
  logic        [DATA_WIDTH:0]    scaled;

  // Arithmetic shift, optional rectification, then clamp into the output range.
  // Returns {clamped, value}.
  function automatic logic [DATA_WIDTH:0] scale_sat(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic        [SW-1:0]        sh,
    input logic                        relu
  );
    logic signed [ACC_WIDTH-1:0] s;
    s = a >>> sh;
    if (relu && (s < 0)) s = '0;
    if (s > SAT_MAX)      return {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (s < SAT_MIN) return {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                  return {1'b0, s[DATA_WIDTH-1:0]};
  endfunction

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign beat      = in_valid & in_ready;
  // count is always zero in IDLE, so this also covers a one-row window.
  assign last_beat = beat && (count == CW'(ROWS-1));
  assign out_take  = out_valid & out_ready;
  assign wr_ok     = (state == IDLE) && !beat && (int'(w_row) < ROWS);

  // Row sum of the current beat against the weight row selected by the row count.
  always_comb begin
    row_idx = (count < CW'(ROWS)) ? RW'(count) : '0;
    row_sum = '0;
    prod    = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      prod    = PW'($signed(in_data[k*DATA_WIDTH +: DATA_WIDTH])) * PW'(weights[row_idx][k]);
      row_sum = row_sum + ACC_WIDTH'(prod);
    end
    acc_next  = acc + row_sum;
    shift_eff = (state == IDLE) ? shift   : shift_q;
    relu_eff  = (state == IDLE) ? relu_en : relu_q;
    scaled    = scale_sat(acc_next, shift_eff, relu_eff);
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (beat) state_next = last_beat ? HOLD : ACCUM;
      ACCUM:   if (last_beat) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Accumulator, row count, latched scaling mode, result and write-error flag.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc      <= '0;
      count    <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
      w_err    <= 1'b0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
      w_err <= 1'b0;
    end else begin
      w_err <= w_we && !wr_ok;
      if (beat) begin
        acc   <= acc_next;
        count <= count + 1'b1;
        if (state == IDLE) begin
          shift_q <= shift;
          relu_q  <= relu_en;
        end
        if (last_beat) {out_sat, out_data} <= scaled;
      end
      if (out_take) begin
        acc   <= '0;
        count <= '0;
      end
    end
  end

  // Weight storage; survives clear and windows, only accepted writes change it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < KERNEL_SIZE; k++)
          weights[r][k] <= '0;
    end else if (!clear && w_we && wr_ok) begin
      for (int k = 0; k < KERNEL_SIZE; k++)
        weights[w_row][k] <= $signed(w_data[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench for conv_stream_engine with DATA_WIDTH=16, KERNEL_SIZE=3, CHANNELS=1.
module tb_conv_stream_engine;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        clear;
  logic        w_we;
  logic [1:0]  w_row;
  logic [47:0] w_data;
  logic        w_err;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic [5:0]  shift;
  logic        relu_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  int checks = 0;
  int errors = 0;

  conv_stream_engine #(.DATA_WIDTH(16), .KERNEL_SIZE(3), .CHANNELS(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .clear(clear),
    .w_we(w_we), .w_row(w_row), .w_data(w_data), .w_err(w_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .shift(shift), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [47:0] pk(input int a, input int b, input int c);
    return {c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] r, input logic [47:0] d);
    @(negedge Clk); w_we = 1'b1; w_row = r; w_data = d;
    @(negedge Clk); w_we = 1'b0;
  endtask

  task automatic wr_all(input int v);
    for (int r = 0; r < 3; r++) wr(2'(r), pk(v, v, v));
  endtask

  task automatic beat(input logic [47:0] d);
    @(negedge Clk); in_valid = 1'b1; in_data = d;
    @(negedge Clk); in_valid = 1'b0;
  endtask

  task automatic take();
    @(negedge Clk); out_ready = 1'b1;
    @(negedge Clk); out_ready = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; clear = 1'b0; w_we = 1'b0; w_row = '0; w_data = '0;
    in_valid = 1'b0; in_data = '0; shift = '0; relu_en = 1'b0; out_ready = 1'b0;
    #23;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_w_err", w_err, 0);
    @(negedge Clk); Rst_n = 1'b1;

    // Plain 3x3 sum of 1..9 with all-ones weights.
    wr_all(1);
    chk("wr_ok_no_err", w_err, 0);
    beat(pk(1, 2, 3));
    beat(pk(4, 5, 6));
    chk("mid_window_no_valid", out_valid, 0);
    chk("mid_window_busy", busy, 1);
    beat(pk(7, 8, 9));
    chk("latency_valid", out_valid, 1);
    chk("sum45_data", $signed(out_data), 45);
    chk("sum45_sat", out_sat, 0);
    chk("hold_in_ready", in_ready, 0);
    take();
    chk("after_take_valid", out_valid, 0);
    chk("after_take_busy", busy, 0);

    // Back-pressure in HOLD: stalled output, offered beats, rejected weight write.
    beat(pk(1, 1, 1));
    @(negedge Clk);
    beat(pk(1, 1, 1));
    beat(pk(1, 1, 1));
    chk("stall_sum9", $signed(out_data), 9);
    @(negedge Clk); in_valid = 1'b1; in_data = pk(100, 100, 100);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("hold_stable_data", $signed(out_data), 9);
      chk("hold_no_ready", in_ready, 0);
    end
    w_we = 1'b1; w_row = 2'd0; w_data = pk(5, 5, 5);
    @(negedge Clk); w_we = 1'b0;
    chk("hold_wr_err_pulse", w_err, 1);
    @(negedge Clk);
    chk("hold_wr_err_one_cycle", w_err, 0);
    chk("hold_still_valid", out_valid, 1);
    in_valid = 1'b0;
    take();
    chk("hold_released", out_valid, 0);
    beat(pk(1, 1, 1));
    beat(pk(1, 1, 1));
    beat(pk(1, 1, 1));
    chk("weights_unchanged_after_hold_wr", $signed(out_data), 9);
    take();

    // Identity-centre weights; relu sampled at window start only.
    wr(2'd0, pk(0, 0, 0));
    wr(2'd1, pk(0, 1, 0));
    wr(2'd2, pk(0, 0, 0));
    relu_en = 1'b1;
    beat(pk(9, 9, 9));
    relu_en = 1'b0;
    beat(pk(0, -5, 0));
    beat(pk(9, 9, 9));
    chk("relu_clamps_neg", $signed(out_data), 0);
    chk("relu_no_sat", out_sat, 0);
    take();
    beat(pk(9, 9, 9));
    beat(pk(0, -5, 0));
    beat(pk(9, 9, 9));
    chk("no_relu_neg5", $signed(out_data), -5);
    take();

    // Saturation: positive clamp, shift bringing it in range, negative clamp.
    wr_all(32767);
    for (int i = 0; i < 3; i++) beat(pk(32767, 32767, 32767));
    chk("sat_pos_data", $signed(out_data), 32767);
    chk("sat_pos_flag", out_sat, 1);
    take();
    shift = 6'd30;
    beat(pk(32767, 32767, 32767));
    shift = 6'd0;
    beat(pk(32767, 32767, 32767));
    beat(pk(32767, 32767, 32767));
    chk("shift30_data", $signed(out_data), 8);
    chk("shift30_flag", out_sat, 0);
    take();
    for (int i = 0; i < 3; i++) beat(pk(-32768, -32768, -32768));
    chk("sat_neg_data", $signed(out_data), -32768);
    chk("sat_neg_flag", out_sat, 1);
    take();

    // Clear mid-window, clear beating a weight write, out-of-range row, beat colliding with write.
    wr_all(1);
    wr(2'd3, pk(7, 7, 7));
    chk("bad_row_err", w_err, 1);
    beat(pk(1, 1, 1));
    beat(pk(1, 1, 1));
    @(negedge Clk); clear = 1'b1; w_we = 1'b1; w_row = 2'd0; w_data = pk(7, 7, 7);
    @(negedge Clk); clear = 1'b0; w_we = 1'b0;
    chk("clear_idle", busy, 0);
    chk("clear_no_valid", out_valid, 0);
    chk("clear_wr_no_err", w_err, 0);
    @(negedge Clk); in_valid = 1'b1; in_data = pk(1, 1, 1);
    w_we = 1'b1; w_row = 2'd0; w_data = pk(3, 3, 3);
    @(negedge Clk); in_valid = 1'b0; w_we = 1'b0;
    chk("beat_collision_err", w_err, 1);
    beat(pk(1, 1, 1));
    beat(pk(1, 1, 1));
    chk("after_clear_sum9", $signed(out_data), 9);
    chk("after_clear_valid", out_valid, 1);
    take();

    // Asynchronous reset during ACCUM and during HOLD.
    beat(pk(1, 1, 1));
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_accum_busy", busy, 0);
    chk("rst_accum_ready", in_ready, 1);
    @(negedge Clk); Rst_n = 1'b1;
    chk("rst_accum_no_valid", out_valid, 0);
    wr_all(1);
    for (int i = 0; i < 3; i++) beat(pk(2, 2, 2));
    chk("pre_rst_hold_valid", out_valid, 1);
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_data", out_data, 0);
    chk("rst_hold_busy", busy, 0);
    @(negedge Clk); Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) beat(pk(4, 4, 4));
    chk("zero_weights_data", $signed(out_data), 0);
    chk("zero_weights_valid", out_valid, 1);
    chk("zero_weights_sat", out_sat, 0);
    take();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
